iomem_arbiter: RTL and testbench

- Two-master, one-slave arbiter for the picosoc iomem bus (valid/ready native interface; ready is a one-cycle pulse).
- Master 0 is the CPU iomem port. Master 1 is a secondary bus master, e.g. an audio DMA or debug bridge.
- Shares the single downstream iomem peripheral bus (GPIO/LED register block and future peripherals) using round-robin arbitration.
- Includes a watchdog timeout so a silent slave cannot hang the CPU.

---
 rtl/iomem_pkg.sv | 18 +
 rtl/iomem_timeout_cnt.sv | 38 +++
 rtl/iomem_arbiter.sv | 113 +++++++++++
 tb/tb_iomem_arbiter.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/iomem_pkg.sv
// rtl/iomem_pkg.sv - shared types and constants for the iomem arbiter slice
package iomem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } iomem_state_t;

    localparam logic [31:0] IOMEM_ERR_DATA      = 32'hDEAD_BEEF;
    localparam logic [7:0]  IOMEM_PERIPH_REGION = 8'h03;

    // Downstream decoders select the peripheral space on the top address byte.
    function automatic logic is_periph_addr(input logic [31:0] addr);
        return addr[31:24] == IOMEM_PERIPH_REGION;
    endfunction

endpackage

// File: rtl/iomem_timeout_cnt.sv
// rtl/iomem_timeout_cnt.sv - per-transfer wait counter with limit compare and saturating event count
module iomem_timeout_cnt #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             active,
    input  logic             stall,
    output logic             hit,
    output logic [CNT_W-1:0] event_count
);

    localparam int                WAIT_W = $clog2(TIMEOUT);
    localparam logic [WAIT_W-1:0] LIMIT  = WAIT_W'(TIMEOUT - 1);

    logic [WAIT_W-1:0] wait_cnt;

    // A slave reply in the limit cycle suppresses the hit via stall.
    assign hit = active && stall && (wait_cnt == LIMIT);

    always_ff @(posedge clk) begin
        if (!resetn || !active) begin
            wait_cnt <= '0;
        end else if (stall) begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            event_count <= '0;
        end else if (hit && (event_count != {CNT_W{1'b1}})) begin
            event_count <= event_count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/iomem_arbiter.sv
// rtl/iomem_arbiter.sv - two-master round-robin iomem arbiter with watchdog timeout
module iomem_arbiter
    import iomem_pkg::*;
#(
    parameter int          TIMEOUT  = 64,
    parameter logic [31:0] ERR_DATA = IOMEM_ERR_DATA,
    parameter int          CNT_W    = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             m0_valid,
    output logic             m0_ready,
    input  logic [3:0]       m0_wstrb,
    input  logic [31:0]      m0_addr,
    input  logic [31:0]      m0_wdata,
    output logic [31:0]      m0_rdata,
    input  logic             m1_valid,
    output logic             m1_ready,
    input  logic [3:0]       m1_wstrb,
    input  logic [31:0]      m1_addr,
    input  logic [31:0]      m1_wdata,
    output logic [31:0]      m1_rdata,
    output logic             s_valid,
    input  logic             s_ready,
    output logic [3:0]       s_wstrb,
    output logic [31:0]      s_addr,
    output logic [31:0]      s_wdata,
    input  logic [31:0]      s_rdata,
    output logic             timeout_pulse,
    output logic [CNT_W-1:0] timeout_count
);

    iomem_state_t state, state_nxt;
    logic         last_grant, last_grant_nxt;
    logic         grant0, grant1, active, timeout_hit;
    logic [31:0]  reply_data;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= IDLE;
            last_grant <= 1'b1;
        end else begin
            state      <= state_nxt;
            last_grant <= last_grant_nxt;
        end
    end

    // Qualified by resetn so a transfer cut by reset never completes.
    assign grant0 = resetn && (state == GRANT0);
    assign grant1 = resetn && (state == GRANT1);
    assign active = (grant0 && m0_valid) || (grant1 && m1_valid);

    always_comb begin
        state_nxt      = state;
        last_grant_nxt = last_grant;
        case (state)
            IDLE: begin
                if (m0_valid && (!m1_valid || last_grant)) begin
                    state_nxt      = GRANT0;
                    last_grant_nxt = 1'b0;
                end else if (m1_valid) begin
                    state_nxt      = GRANT1;
                    last_grant_nxt = 1'b1;
                end
            end
            GRANT0: begin
                if (!m0_valid || s_ready || timeout_hit) state_nxt = IDLE;
            end
            GRANT1: begin
                if (!m1_valid || s_ready || timeout_hit) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        s_valid = 1'b0;
        s_wstrb = 4'd0;
        s_addr  = 32'd0;
        s_wdata = 32'd0;
        if (grant0) begin
            s_valid = m0_valid;
            s_wstrb = m0_wstrb;
            s_addr  = m0_addr;
            s_wdata = m0_wdata;
        end else if (grant1) begin
            s_valid = m1_valid;
            s_wstrb = m1_wstrb;
            s_addr  = m1_addr;
            s_wdata = m1_wdata;
        end
    end

    assign reply_data    = timeout_hit ? ERR_DATA : s_rdata;
    assign m0_ready      = grant0 && m0_valid && (s_ready || timeout_hit);
    assign m1_ready      = grant1 && m1_valid && (s_ready || timeout_hit);
    assign m0_rdata      = grant0 ? reply_data : 32'd0;
    assign m1_rdata      = grant1 ? reply_data : 32'd0;
    assign timeout_pulse = timeout_hit;

    iomem_timeout_cnt #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_timeout_cnt (
        .clk         (clk),
        .resetn      (resetn),
        .active      (active),
        .stall       (!s_ready),
        .hit         (timeout_hit),
        .event_count (timeout_count)
    );

endmodule

// File: tb/tb_iomem_arbiter.sv
// tb/tb_iomem_arbiter.sv - directed self-checking bench for iomem_arbiter
module tb_iomem_arbiter;

    logic        clk = 1'b0;
    logic        resetn;
    logic        m0_valid, m0_ready, m1_valid, m1_ready;
    logic [3:0]  m0_wstrb, m1_wstrb, s_wstrb;
    logic [31:0] m0_addr, m0_wdata, m0_rdata, m1_addr, m1_wdata, m1_rdata;
    logic        s_valid, s_ready;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic        timeout_pulse;
    logic [7:0]  timeout_count;
    logic [31:0] gpio;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    iomem_arbiter #(.TIMEOUT(64), .ERR_DATA(32'hDEAD_BEEF), .CNT_W(8)) dut (
        .clk           (clk),
        .resetn        (resetn),
        .m0_valid      (m0_valid),
        .m0_ready      (m0_ready),
        .m0_wstrb      (m0_wstrb),
        .m0_addr       (m0_addr),
        .m0_wdata      (m0_wdata),
        .m0_rdata      (m0_rdata),
        .m1_valid      (m1_valid),
        .m1_ready      (m1_ready),
        .m1_wstrb      (m1_wstrb),
        .m1_addr       (m1_addr),
        .m1_wdata      (m1_wdata),
        .m1_rdata      (m1_rdata),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .s_wstrb       (s_wstrb),
        .s_addr        (s_addr),
        .s_wdata       (s_wdata),
        .s_rdata       (s_rdata),
        .timeout_pulse (timeout_pulse),
        .timeout_count (timeout_count)
    );

    // Slave-side GPIO register with byte strobes.
    always @(posedge clk) begin
        if (s_valid && s_ready && s_wstrb != 4'd0) begin
            for (int b = 0; b < 4; b++)
                if (s_wstrb[b]) gpio[b*8 +: 8] <= s_wdata[b*8 +: 8];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        m0_valid = 0; m1_valid = 0; s_ready = 0; s_rdata = 0;
        m0_wstrb = 0; m1_wstrb = 0; m0_wdata = 0; m1_wdata = 0;
        m0_addr = 32'h0300_0000; m1_addr = 32'h0300_0004;
    endtask

    task automatic test_reset();
        idle_inputs();
        gpio = 0;
        resetn = 0;
        tick(); tick();
        #1;
        checks++;
        if ({m0_ready, m1_ready, s_valid, timeout_pulse} !== 4'b0) begin
            failures++; $display("FAIL reset_ctrl got=%b want=0000", {m0_ready, m1_ready, s_valid, timeout_pulse});
        end
        checks++;
        if ({s_addr, s_wdata, s_wstrb, m0_rdata, m1_rdata} !== 132'd0) begin
            failures++; $display("FAIL reset_data got=%h want=0", {s_addr, s_wdata, s_wstrb, m0_rdata, m1_rdata});
        end
        checks++;
        if (timeout_count !== 8'd0) begin
            failures++; $display("FAIL reset_count got=%0d want=0", timeout_count);
        end
        resetn = 1;
        tick();
    endtask

    task automatic test_m0_read();
        m0_valid = 1; m0_addr = 32'h0300_0000; m0_wstrb = 0;
        #1;
        checks++;
        if (s_valid !== 1'b0) begin
            failures++; $display("FAIL rd_req_cycle_svalid got=%b want=0", s_valid);
        end
        tick();
        checks++;
        if (s_valid !== 1'b1 || s_addr !== 32'h0300_0000) begin
            failures++; $display("FAIL rd_grant got=%b/%h want=1/03000000", s_valid, s_addr);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (m0_ready !== 1'b0 || m1_ready !== 1'b0) begin
                failures++; $display("FAIL rd_wait%0d ready got=%b%b want=00", i, m0_ready, m1_ready);
            end
            tick();
        end
        s_ready = 1; s_rdata = 32'h0000_00A5;
        #1;
        checks++;
        if (m0_ready !== 1'b1 || m0_rdata !== 32'h0000_00A5 || m1_ready !== 1'b0) begin
            failures++; $display("FAIL rd_done got=%b/%h/%b want=1/000000a5/0", m0_ready, m0_rdata, m1_ready);
        end
        tick();
        m0_valid = 0; s_ready = 0; s_rdata = 0;
        #1;
        checks++;
        if (m0_ready !== 1'b0 || s_valid !== 1'b0 || timeout_count !== 8'd0) begin
            failures++; $display("FAIL rd_after got=%b/%b/%0d want=0/0/0", m0_ready, s_valid, timeout_count);
        end
    endtask

    task automatic test_round_robin();
        int expect_m;
        resetn = 0;
        idle_inputs();
        tick();
        resetn = 1;
        m0_valid = 1; m1_valid = 1;
        for (int t = 0; t < 8; t++) begin
            expect_m = t % 2;
            s_ready = 0;
            #1;
            checks++;
            if (s_valid !== 1'b0) begin
                failures++; $display("FAIL rr_idle%0d s_valid got=%b want=0", t, s_valid);
            end
            tick();
            s_ready = 1; s_rdata = 32'h100 + t;
            #1;
            checks++;
            if (s_addr !== (expect_m == 0 ? 32'h0300_0000 : 32'h0300_0004) ||
                m0_ready !== (expect_m == 0) || m1_ready !== (expect_m == 1)) begin
                failures++; $display("FAIL rr_grant%0d got addr=%h r=%b%b want master %0d", t, s_addr, m0_ready, m1_ready, expect_m);
            end
            tick();
        end
        m0_valid = 0; m1_valid = 0; s_ready = 0;
        tick();
    endtask

    task automatic test_m1_write();
        m1_valid = 1; m1_wstrb = 4'b0011; m1_wdata = 32'h1234_5678;
        tick();
        checks++;
        if (s_valid !== 1'b1 || s_wstrb !== 4'b0011 || s_wdata !== 32'h1234_5678 || s_addr !== 32'h0300_0004) begin
            failures++; $display("FAIL wr_mux got=%b/%b/%h/%h want=1/0011/12345678/03000004", s_valid, s_wstrb, s_wdata, s_addr);
        end
        s_ready = 1;
        #1;
        checks++;
        if (m1_ready !== 1'b1 || m0_ready !== 1'b0) begin
            failures++; $display("FAIL wr_ready got=%b%b want=01", m0_ready, m1_ready);
        end
        tick();
        m1_valid = 0; m1_wstrb = 0; s_ready = 0;
        checks++;
        if (gpio[15:0] !== 16'h5678) begin
            failures++; $display("FAIL wr_gpio got=%h want=5678", gpio[15:0]);
        end
        tick();
    endtask

    task automatic test_timeout();
        m0_valid = 1; m0_wstrb = 0;
        tick();
        for (int k = 1; k <= 64; k++) begin
            #1;
            checks++;
            if (timeout_pulse !== (k == 64) || m0_ready !== (k == 64)) begin
                failures++; $display("FAIL to_cycle%0d got pulse=%b ready=%b want=%b", k, timeout_pulse, m0_ready, k == 64);
            end
            if (k == 64) begin
                checks++;
                if (m0_rdata !== 32'hDEAD_BEEF) begin
                    failures++; $display("FAIL to_rdata got=%h want=deadbeef", m0_rdata);
                end
            end
            tick();
        end
        m0_valid = 0;
        #1;
        checks++;
        if (timeout_count !== 8'd1 || s_valid !== 1'b0) begin
            failures++; $display("FAIL to_after got=%0d/%b want=1/0", timeout_count, s_valid);
        end
        m1_valid = 1;
        tick();
        s_ready = 1; s_rdata = 32'h0000_0077;
        #1;
        checks++;
        if (m1_ready !== 1'b1 || m1_rdata !== 32'h0000_0077 || timeout_pulse !== 1'b0) begin
            failures++; $display("FAIL to_next got=%b/%h/%b want=1/00000077/0", m1_ready, m1_rdata, timeout_pulse);
        end
        tick();
        m1_valid = 0; s_ready = 0;
        tick();
    endtask

    task automatic test_limit_ready();
        m0_valid = 1;
        tick();
        for (int k = 1; k < 64; k++) tick();
        s_ready = 1; s_rdata = 32'h0000_CAFE;
        #1;
        checks++;
        if (m0_ready !== 1'b1 || m0_rdata !== 32'h0000_CAFE || timeout_pulse !== 1'b0) begin
            failures++; $display("FAIL lim_done got=%b/%h/%b want=1/0000cafe/0", m0_ready, m0_rdata, timeout_pulse);
        end
        tick();
        m0_valid = 0; s_ready = 0;
        #1;
        checks++;
        if (timeout_count !== 8'd1) begin
            failures++; $display("FAIL lim_count got=%0d want=1", timeout_count);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        m1_valid = 1;
        tick();
        checks++;
        if (s_valid !== 1'b1 || s_addr !== 32'h0300_0004) begin
            failures++; $display("FAIL rm_grant1 got=%b/%h want=1/03000004", s_valid, s_addr);
        end
        resetn = 0; m0_valid = 1; s_ready = 1;
        #1;
        checks++;
        if (m1_ready !== 1'b0 || m0_ready !== 1'b0) begin
            failures++; $display("FAIL rm_ready got=%b%b want=00", m0_ready, m1_ready);
        end
        tick();
        resetn = 1; s_ready = 0;
        #1;
        checks++;
        if (s_valid !== 1'b0 || m1_ready !== 1'b0 || timeout_count !== 8'd0) begin
            failures++; $display("FAIL rm_idle got=%b/%b/%0d want=0/0/0", s_valid, m1_ready, timeout_count);
        end
        tick();
        s_ready = 1;
        #1;
        checks++;
        if (s_addr !== 32'h0300_0000 || m0_ready !== 1'b1 || m1_ready !== 1'b0) begin
            failures++; $display("FAIL rm_tie got addr=%h r=%b%b want=03000000/10", s_addr, m0_ready, m1_ready);
        end
        tick();
        idle_inputs();
        tick();
    endtask

    initial begin
        test_reset();
        test_m0_read();
        test_round_robin();
        test_m1_write();
        test_timeout();
        test_limit_ready();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
